pc_sequencer: RTL

- Registered program-counter unit; successor to the combinational next-address selector.
- Holds the PC and computes the next address every cycle from a mode code: sequential, absolute branch, PC-relative branch, register jump, call, return or halt.
- Contains a parametrised hardware return-address stack with sticky overflow/underflow flags.
- Sits between instruction-memory addressing and the control unit; its PC drives the instruction memory directly.

---
 rtl/pc_sequencer_if.sv | 31 +++
 rtl/pc_sequencer.sv | 131 +++++++++++++
 2 files changed

// File: rtl/pc_sequencer_if.sv
// Bundle between the control unit and the program-counter sequencer.
// The master side supplies the mode/condition/targets; the slave returns PC and stack status.
interface pc_sequencer_if #(
    parameter int unsigned ADDR_WIDTH  = 10,
    parameter int unsigned IMM_WIDTH   = 32,
    parameter int unsigned STACK_DEPTH = 8
);
    localparam int unsigned CntW = $clog2(STACK_DEPTH) + 1;

    logic                  enable;
    logic [2:0]            mode;
    logic                  taken;
    logic [IMM_WIDTH-1:0]  imm;
    logic [ADDR_WIDTH-1:0] reg_target;
    logic [ADDR_WIDTH-1:0] pc;
    logic [ADDR_WIDTH-1:0] next_pc;
    logic [CntW-1:0]       stack_count;
    logic                  halted;
    logic                  overflow;
    logic                  underflow;

    modport master (
        output enable, mode, taken, imm, reg_target,
        input  pc, next_pc, stack_count, halted, overflow, underflow
    );

    modport slave (
        input  enable, mode, taken, imm, reg_target,
        output pc, next_pc, stack_count, halted, overflow, underflow
    );
endinterface

// File: rtl/pc_sequencer.sv
// Registered program counter with next-address selection and a hardware return-address stack.
module pc_sequencer #(
    parameter int unsigned          ADDR_WIDTH  = 10,
    parameter int unsigned          IMM_WIDTH   = 32,
    parameter int unsigned          STACK_DEPTH = 8,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
    input logic           clock,
    input logic           reset,
    pc_sequencer_if.slave bus
);
    localparam int unsigned CntW  = $clog2(STACK_DEPTH) + 1;
    localparam int unsigned IdxW  = $clog2(STACK_DEPTH);
    localparam int unsigned WideW = (IMM_WIDTH > ADDR_WIDTH) ? IMM_WIDTH : ADDR_WIDTH;

    localparam logic [2:0] ModeSeq  = 3'd0;
    localparam logic [2:0] ModeAbs  = 3'd1;
    localparam logic [2:0] ModeRel  = 3'd2;
    localparam logic [2:0] ModeJr   = 3'd3;
    localparam logic [2:0] ModeCall = 3'd4;
    localparam logic [2:0] ModeRet  = 3'd5;
    localparam logic [2:0] ModeHalt = 3'd6;

    typedef enum logic [0:0] {StRun, StHalted} state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic [CntW-1:0]       count_q, count_d;
    logic                  ovf_q, ovf_d;
    logic                  unf_q, unf_d;
    logic                  push;

    logic [ADDR_WIDTH-1:0] stack_mem [STACK_DEPTH];

    logic [ADDR_WIDTH-1:0] seq;
    logic [ADDR_WIDTH-1:0] next_pc;
    logic [ADDR_WIDTH-1:0] abs_target;
    logic [ADDR_WIDTH-1:0] rel_target;
    logic [ADDR_WIDTH-1:0] stack_top;
    logic [WideW-1:0]      imm_zx;
    logic [WideW-1:0]      imm_sx;
    logic                  full;
    logic                  empty;

    // Target arithmetic shared by all modes; relative offsets wrap modulo the PC width.
    always_comb begin
        imm_zx     = WideW'(bus.imm);
        imm_sx     = WideW'($signed(bus.imm));
        seq        = pc_q + ADDR_WIDTH'(1);
        abs_target = imm_zx[ADDR_WIDTH-1:0];
        rel_target = pc_q + imm_sx[ADDR_WIDTH-1:0];
        full       = (count_q == CntW'(STACK_DEPTH));
        empty      = (count_q == '0);
        stack_top  = stack_mem[IdxW'(count_q - CntW'(1))];
    end

    // Next-address selection, stack bookkeeping and halt transition.
    always_comb begin
        next_pc = seq;
        state_d = state_q;
        count_d = count_q;
        ovf_d   = ovf_q;
        unf_d   = unf_q;
        push    = 1'b0;
        if (state_q == StHalted) begin
            next_pc = pc_q;
        end else begin
            case (bus.mode)
                ModeSeq: next_pc = seq;
                ModeAbs: if (bus.taken) next_pc = abs_target;
                ModeRel: if (bus.taken) next_pc = rel_target;
                ModeJr:  next_pc = bus.reg_target;
                ModeCall: begin
                    if (!full) next_pc = abs_target;
                    if (bus.enable) begin
                        if (full) begin
                            ovf_d = 1'b1;
                        end else begin
                            push    = 1'b1;
                            count_d = count_q + CntW'(1);
                        end
                    end
                end
                ModeRet: begin
                    if (!empty) next_pc = stack_top;
                    if (bus.enable) begin
                        if (empty) unf_d = 1'b1;
                        else       count_d = count_q - CntW'(1);
                    end
                end
                ModeHalt: begin
                    next_pc = pc_q;
                    if (bus.enable) state_d = StHalted;
                end
                default: next_pc = seq;
            endcase
        end
        pc_d = (bus.enable && state_q == StRun) ? next_pc : pc_q;
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= StRun;
            pc_q    <= RESET_PC;
            count_q <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    // Return-address storage; contents deliberately survive reset.
    always_ff @(posedge clock) begin
        if (reset && push) begin
            stack_mem[IdxW'(count_q)] <= seq;
        end
    end

    assign bus.pc          = pc_q;
    assign bus.next_pc     = next_pc;
    assign bus.stack_count = count_q;
    assign bus.halted      = (state_q == StHalted);
    assign bus.overflow    = ovf_q;
    assign bus.underflow   = unf_q;
endmodule
